// File: rtl/insframe_tx.sv
// insframe_tx: instruction-frame transmitter for the I2C instruction path.
// Accepts an addressed instruction, frames it and shifts it out LSB first
// on sdaout with an output enable, then pulses framedone.
// Optional build macro INSFRAME_PARITY_EN inserts an even-parity bit
// (^ins) directly after the instruction field.
//
// Handshake: a request is taken on a clkins edge where startins=1,
// insready=1 and addins==MY_ADDR; insready is high only in IDLE, and
// requests arriving while busy are neither taken nor counted.
module insframe_tx #(
  parameter int                INS_W   = 4,
  parameter int                ADDR_W  = 4,
  parameter logic [ADDR_W-1:0] MY_ADDR = 4'b0010,
  parameter int                PAD_W   = 4,
  parameter int                BIT_CYC = 1,
`ifdef INSFRAME_PARITY_EN
  localparam int               PAR_W   = 1,
`else
  localparam int               PAR_W   = 0,
`endif
  localparam int               FRAME_W = INS_W + PAD_W + 4 + PAR_W
) (
  input  logic               clkins,
  input  logic               rstins,
  input  logic               startins,
  input  logic [ADDR_W-1:0]  addins,
  input  logic [INS_W-1:0]   ins,
  output logic               insready,
  output logic               busy,
  output logic               sdaout,
  output logic               sdaoe,
  output logic               framedone,
  output logic [FRAME_W-1:0] inssend,
  output logic [7:0]         rejcnt,
  output logic [1:0]         fsmstate
);

  localparam int BIT_W = $clog2(FRAME_W);
  localparam int CYC_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FRAME_W-1:0] sh_q, sh_d;
  logic [FRAME_W-1:0] send_q, send_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [CYC_W-1:0]   cyc_q, cyc_d;
  logic               sda_q, sda_d;
  logic               oe_q, oe_d;
  logic               done_q, done_d;
  logic [7:0]         rej_q, rej_d;
  logic [FRAME_W-1:0] frame;

  // Build the frame: two start ones, payload, optional parity, pad zeros, two tail ones
  always_comb begin
    frame             = '0;
    frame[0]          = 1'b1;
    frame[1]          = 1'b1;
    frame[2 +: INS_W] = ins;
`ifdef INSFRAME_PARITY_EN
    frame[2 + INS_W]  = ^ins;
`endif
    frame[FRAME_W-2]  = 1'b1;
    frame[FRAME_W-1]  = 1'b1;
  end

  // Next-state and next-output logic; framedone defaults low so it only pulses
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    send_d  = send_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    sda_d   = sda_q;
    oe_d    = oe_q;
    done_d  = 1'b0;
    rej_d   = rej_q;
    case (state_q)
      IDLE: begin
        if (startins) begin
          if (addins == MY_ADDR) begin
            state_d = SHIFT;
            sh_d    = frame;
            send_d  = frame;
            sda_d   = frame[0];
            oe_d    = 1'b1;
            bit_d   = '0;
            cyc_d   = '0;
          end else if (rej_q != 8'hFF) begin
            rej_d = rej_q + 8'd1;
          end
        end
      end
      SHIFT: begin
        if (cyc_q == CYC_W'(BIT_CYC - 1)) begin
          cyc_d = '0;
          if (bit_q == BIT_W'(FRAME_W - 1)) begin
            sda_d   = 1'b0;
            oe_d    = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            sh_d  = sh_q >> 1;
            sda_d = sh_q[1];
          end
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset aborts any frame in flight
  always_ff @(posedge clkins) begin
    if (rstins) begin
      state_q <= IDLE;
      sh_q    <= '0;
      send_q  <= '0;
      bit_q   <= '0;
      cyc_q   <= '0;
      sda_q   <= 1'b0;
      oe_q    <= 1'b0;
      done_q  <= 1'b0;
      rej_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      send_q  <= send_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      sda_q   <= sda_d;
      oe_q    <= oe_d;
      done_q  <= done_d;
      rej_q   <= rej_d;
    end
  end

  assign insready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign sdaout    = sda_q;
  assign sdaoe     = oe_q;
  assign framedone = done_q;
  assign inssend   = send_q;
  assign rejcnt    = rej_q;
  assign fsmstate  = state_q;

endmodule
